// File: rtl/approx_mul_if.sv
// approx_mul_if: config, operand and result handshake bundle for approx_mul_pipe
interface approx_mul_if #(parameter int WIDTH = 8);
  logic cfg_we;
  logic [7:0] cfg_mode;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [31:0] err_cnt;
  logic [31:0] err_sum;
  modport master (
    output cfg_we, cfg_mode, in_valid, in_a, in_b, out_ready,
    input in_ready, out_valid, out_prod, err_cnt, err_sum
  );
  modport slave (
    input cfg_we, cfg_mode, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, err_cnt, err_sum
  );
endinterface

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: pipelined per-quadrant approximate multiplier; APPROX_MUL_ERRSTAT_EN adds error counters
module approx_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2
) (
  input logic clk,
  input logic rst,
  approx_mul_if.slave bus
);
  localparam int H = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] M_TR = {{(WIDTH-TRUNC){1'b1}}, {TRUNC{1'b0}}};
  localparam logic [WIDTH-1:0] M_H = {{H{1'b1}}, {H{1'b0}}};
  logic advance;
  logic v1_q, v2_q, v3_q, v4_q;
  logic [7:0] mode_q, m1_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic [WIDTH-1:0] ll_q, lh_q, hl_q, hh_q, ll_d, lh_d, hl_d, hh_d;
  logic [WIDTH:0] mid_q, mid_d;
  logic [W2-1:0] cat_q, prod_q, prod_d;
  function automatic logic [WIDTH-1:0] qm(input logic [1:0] m, input logic [WIDTH-1:0] p);
    return m == 2'b00 ? p : m == 2'b01 ? p & M_TR : m == 2'b10 ? p & M_H : '0;
  endfunction
  always_comb begin
    ll_d = qm(m1_q[1:0], WIDTH'(a1_q[H-1:0]) * WIDTH'(b1_q[H-1:0]));
    lh_d = qm(m1_q[3:2], WIDTH'(a1_q[H-1:0]) * WIDTH'(b1_q[WIDTH-1:H]));
    hl_d = qm(m1_q[5:4], WIDTH'(a1_q[WIDTH-1:H]) * WIDTH'(b1_q[H-1:0]));
    hh_d = qm(m1_q[7:6], WIDTH'(a1_q[WIDTH-1:H]) * WIDTH'(b1_q[WIDTH-1:H]));
    mid_d = {1'b0, hl_q} + {1'b0, lh_q};
    prod_d = cat_q + (W2'(mid_q) << H);
  end
  assign advance = !v4_q || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = v4_q;
  assign bus.out_prod = prod_q;
  // HH and LL never overlap, so they concatenate; the cross terms are added in a final register
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      mode_q <= '0;
      m1_q <= '0;
      a1_q <= '0;
      b1_q <= '0;
      {ll_q, lh_q, hl_q, hh_q} <= '0;
      mid_q <= '0;
      cat_q <= '0;
      prod_q <= '0;
    end else begin
      if (bus.cfg_we) mode_q <= bus.cfg_mode;
      if (advance) begin
        v1_q <= bus.in_valid;
        v2_q <= v1_q;
        v3_q <= v2_q;
        v4_q <= v3_q;
        if (bus.in_valid) begin
          a1_q <= bus.in_a;
          b1_q <= bus.in_b;
          m1_q <= mode_q;
        end
        if (v1_q) begin
          ll_q <= ll_d;
          lh_q <= lh_d;
          hl_q <= hl_d;
          hh_q <= hh_d;
        end
        if (v2_q) begin
          cat_q <= {hh_q, ll_q};
          mid_q <= mid_d;
        end
        if (v3_q) prod_q <= prod_d;
      end
    end
  end
`ifdef APPROX_MUL_ERRSTAT_EN
  localparam int SW = (W2 > 32 ? W2 : 32) + 1;
  logic [W2-1:0] ex2_q, ex3_q, ex4_q, diff;
  logic [31:0] err_cnt_q, err_sum_q;
  logic [SW-1:0] sum_d;
  assign diff = ex4_q >= prod_q ? ex4_q - prod_q : prod_q - ex4_q;
  assign sum_d = SW'(err_sum_q) + SW'(diff);
  always_ff @(posedge clk) begin
    if (rst) begin
      {ex2_q, ex3_q, ex4_q} <= '0;
      err_cnt_q <= '0;
      err_sum_q <= '0;
    end else begin
      if (advance) begin
        if (v1_q) ex2_q <= W2'(a1_q) * W2'(b1_q);
        if (v2_q) ex3_q <= ex2_q;
        if (v3_q) ex4_q <= ex3_q;
      end
      if (v4_q && bus.out_ready) begin
        if (diff != '0 && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
        err_sum_q <= |sum_d[SW-1:32] ? '1 : sum_d[31:0];
      end
    end
  end
  assign bus.err_cnt = err_cnt_q;
  assign bus.err_sum = err_sum_q;
`else
  assign bus.err_cnt = '0;
  assign bus.err_sum = '0;
`endif
endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe: scoreboard bench for approx_mul_pipe at WIDTH=8 (directed + random) and WIDTH=16 (exact random)
module tb_approx_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  approx_mul_if #(.WIDTH(8)) b8 ();
  approx_mul_if #(.WIDTH(16)) b16 ();
  approx_mul_pipe #(.WIDTH(8), .TRUNC(2)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  approx_mul_pipe #(.WIDTH(16), .TRUNC(2)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  typedef struct packed {
    logic [15:0] prod;
    logic [15:0] exact;
  } e8_t;
  e8_t q8[$];
  logic [31:0] q16[$];
  logic [7:0] cur_mode = 8'h00;
  longint ec = 0;
  longint es = 0;
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endfunction
  // quadrant-wise product: each half-product rounded down per its mode, then weighted by position
  function automatic logic [15:0] approx8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    longint al = a % 16, ah = a / 16, bl = b % 16, bh = b / 16;
    longint p[4] = '{al * bl, al * bh, ah * bl, ah * bh};
    longint w[4] = '{1, 16, 16, 256};
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      int md = int'(m[2*i +: 2]);
      longint qv = md == 0 ? p[i] : md == 1 ? p[i] - p[i] % 4 : md == 2 ? p[i] - p[i] % 16 : 0;
      s += qv * w[i];
    end
    return s[15:0];
  endfunction
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic rdy,
                       input logic we, input logic [7:0] m, input logic r, output logic acc);
    @(negedge clk);
    rst = r;
    b8.in_valid = v;
    b8.in_a = a;
    b8.in_b = b;
    b8.out_ready = rdy;
    b8.cfg_we = we;
    b8.cfg_mode = m;
    #1 acc = v && b8.in_ready;
    @(posedge clk);
    if (acc) q8.push_back('{prod: approx8(a, b, cur_mode), exact: 16'(a) * 16'(b)});
    if (r) begin
      q8.delete();
      cur_mode = 8'h00;
    end else if (we) cur_mode = m;
  endtask
  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, acc);
  endtask
  task automatic cycle16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic rdy, output logic acc);
    @(negedge clk);
    b16.in_valid = v;
    b16.in_a = a;
    b16.in_b = b;
    b16.out_ready = rdy;
    #1 acc = v && b16.in_ready;
    @(posedge clk);
    if (acc) q16.push_back(32'(a) * 32'(b));
  endtask
  initial begin : mon8
    logic hold = 1'b0;
    logic [15:0] hold_p = '0;
    e8_t e;
    forever begin
      @(negedge clk);
      #2;
      if (hold) begin
        chk("hold_valid", b8.out_valid, 1);
        chk("hold_prod", b8.out_prod, hold_p);
      end
      hold = !rst && b8.out_valid && !b8.out_ready;
      hold_p = b8.out_prod;
`ifdef APPROX_MUL_ERRSTAT_EN
      chk("err_cnt", b8.err_cnt, ec[31:0]);
      chk("err_sum", b8.err_sum, es[31:0]);
`else
      chk("err_cnt", b8.err_cnt, 0);
      chk("err_sum", b8.err_sum, 0);
`endif
      if (rst) begin
        ec = 0;
        es = 0;
      end else if (b8.out_valid && b8.out_ready) begin
        chk("w8_result_expected", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("w8_prod", b8.out_prod, e.prod);
          if (e.prod != e.exact) ec++;
          es += longint'(e.exact) - longint'(e.prod);
        end
      end
    end
  end
  initial begin : mon16
    forever begin
      @(negedge clk);
      #2;
      if (!rst && b16.out_valid && b16.out_ready) begin
        chk("w16_result_expected", q16.size() != 0, 1);
        if (q16.size() != 0) chk("w16_prod", b16.out_prod, q16.pop_front());
      end
    end
  end
  initial begin : drive
    logic acc, rdy, seen, fell, v;
    logic [7:0] a, b;
    logic [15:0] a16, b16v;
    int sent, low, n16, cyc16;
    {b8.cfg_we, b8.cfg_mode, b8.in_valid, b8.in_a, b8.in_b, b8.out_ready} = '0;
    {b16.cfg_we, b16.cfg_mode, b16.in_valid, b16.in_a, b16.in_b} = '0;
    b16.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_out_prod", b8.out_prod, 0);
    chk("rst_in_ready", b8.in_ready, 1);
    chk("rst_err_cnt", b8.err_cnt, 0);
    chk("rst_err_sum", b8.err_sum, 0);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, acc);
    chk("t1_accept", acc, 1);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, acc);
      #1 chk("t1_latency_valid", b8.out_valid, k == 3);
    end
    idle(2);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, acc);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, acc);
    idle(5);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, acc);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, acc);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, acc);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, acc);
    idle(5);
    sent = 0;
    low = 0;
    seen = 1'b0;
    fell = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    repeat (20) begin
      rdy = !(seen && low < 4);
      if (!rdy) low++;
      v = sent < 6;
      cycle(v, a, b, rdy, 1'b0, 8'h00, 1'b0, acc);
      if (v && acc) begin
        sent++;
        a = 8'($urandom);
        b = 8'($urandom);
      end else if (v) fell = 1'b1;
      #1 if (b8.out_valid) seen = 1'b1;
    end
    chk("stream_sent", sent, 6);
    chk("stream_in_ready_fell", fell, 1);
    chk("stream_drained", q8.size(), 0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, acc);
    repeat (3) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0, 8'h00, 1'b0, acc);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, acc);
    #1;
    chk("flush_out_valid", b8.out_valid, 0);
    chk("flush_err_cnt", b8.err_cnt, 0);
    chk("flush_err_sum", b8.err_sum, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, acc);
      #1 chk("flush_no_stale", b8.out_valid, 0);
    end
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, acc);
    idle(5);
    repeat (1500)
      cycle($urandom_range(3) != 0, 8'($urandom), 8'($urandom), $urandom_range(3) != 0,
            $urandom_range(15) == 0, 8'($urandom), 1'b0, acc);
    idle(10);
    chk("w8_drained", q8.size(), 0);
    n16 = 0;
    cyc16 = 0;
    a16 = 16'($urandom);
    b16v = 16'($urandom);
    while (n16 < 10000 && cyc16 < 20000) begin
      v = $urandom_range(7) != 0;
      cycle16(v, a16, b16v, $urandom_range(7) != 0, acc);
      cyc16++;
      if (acc) begin
        n16++;
        a16 = 16'($urandom);
        b16v = 16'($urandom);
      end
    end
    chk("w16_count", n16, 10000);
    repeat (10) cycle16(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
    chk("w16_drained", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
